// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared widths, state encodings and code-to-digit helper for the input decoder
package sudoku_pkg;

  localparam int CODE_W  = 2;
  localparam int CELL_W  = 4;
  localparam int VAL_W   = 3;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_DIFF = 3'd1;
  localparam logic [STATE_W-1:0] ST_ROW  = 3'd2;
  localparam logic [STATE_W-1:0] ST_COL  = 3'd3;
  localparam logic [STATE_W-1:0] ST_VAL  = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd6;

  localparam logic [VAL_W-1:0] DIGIT_OFFSET = 3'd1;

  function automatic logic [VAL_W-1:0] code_to_digit(input logic [CODE_W-1:0] code);
    return {1'b0, code} + DIGIT_OFFSET;
  endfunction

endpackage

// File: rtl/sudoku_input_decoder_key_edge_detect.sv
// rtl/sudoku_input_decoder_key_edge_detect.sv - turns the level keypress into a one-cycle press pulse
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= 1'b0;
    else     key_q <= key;
  end

  // Combinational so a press is acted on in the same cycle it is seen.
  assign press = key & ~key_q;

endmodule

// File: rtl/sudoku_input_decoder.sv
// rtl/sudoku_input_decoder.sv - decodes difficulty and row/col/val keypresses into handshaked board moves
module sudoku_input_decoder
  import sudoku_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                in_clka,
  input  logic                in_restart,
  input  logic                in_new_game,
  input  logic                in_enter,
  input  logic [CODE_W-1:0]   in_diff_cell_val,
  input  logic                in_move_ready,
  input  logic                in_solved,
  output logic [CODE_W-1:0]   out_diff,
  output logic                out_diff_valid,
  output logic                out_move_valid,
  output logic [CELL_W-1:0]   out_move_cell,
  output logic [VAL_W-1:0]    out_move_val,
  output logic                out_set_diff_flag,
  output logic                out_row_flag,
  output logic                out_col_flag,
  output logic                out_val_flag,
  output logic                out_abort,
  output logic [STATE_W-1:0]  out_state
);

  logic                press;
  logic [STATE_W-1:0]  state, state_next;
  logic [CODE_W-1:0]   row_q, col_q;
  logic [TO_W-1:0]     to_cnt;
  logic                in_entry_window;
  logic                timeout_hit;

  key_edge_detect u_key_edge_detect (
    .clk   (in_clka),
    .rst   (in_restart),
    .key   (in_enter),
    .press (press)
  );

  assign in_entry_window = (state == ST_COL) || (state == ST_VAL);
  // A press in the final cycle wins over the timeout, since it restarts the count.
  assign timeout_hit = (TIMEOUT != 0) && in_entry_window && !press &&
                       (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    if (in_new_game) begin
      state_next = ST_DIFF;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_DIFF: if (press) state_next = ST_ROW;
        ST_ROW: begin
          if (in_solved)  state_next = ST_DONE;
          else if (press) state_next = ST_COL;
        end
        ST_COL: begin
          if (timeout_hit) state_next = ST_ROW;
          else if (press)  state_next = ST_VAL;
        end
        ST_VAL: begin
          if (timeout_hit) state_next = ST_ROW;
          else if (press)  state_next = ST_WAIT;
        end
        ST_WAIT: if (out_move_valid && in_move_ready) state_next = ST_ROW;
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state             <= ST_IDLE;
      row_q             <= '0;
      col_q             <= '0;
      to_cnt            <= '0;
      out_diff          <= '0;
      out_diff_valid    <= 1'b0;
      out_move_valid    <= 1'b0;
      out_move_cell     <= '0;
      out_move_val      <= '0;
      out_set_diff_flag <= 1'b0;
      out_row_flag      <= 1'b0;
      out_col_flag      <= 1'b0;
      out_val_flag      <= 1'b0;
      out_abort         <= 1'b0;
    end else begin
      state          <= state_next;
      out_diff_valid <= 1'b0;
      out_abort      <= 1'b0;
      // Flags are registered from the next state so they never glitch.
      out_set_diff_flag <= (state_next == ST_DIFF);
      out_row_flag      <= (state_next == ST_ROW);
      out_col_flag      <= (state_next == ST_COL);
      out_val_flag      <= (state_next == ST_VAL);

      if (in_new_game) begin
        out_diff       <= '0;
        out_move_valid <= 1'b0;
        out_move_cell  <= '0;
        out_move_val   <= '0;
        row_q          <= '0;
        col_q          <= '0;
        to_cnt         <= '0;
      end else begin
        case (state)
          ST_DIFF: begin
            if (press) begin
              out_diff       <= in_diff_cell_val;
              out_diff_valid <= 1'b1;
            end
          end
          ST_ROW: begin
            if (!in_solved && press) begin
              row_q  <= in_diff_cell_val;
              to_cnt <= '0;
            end
          end
          ST_COL, ST_VAL: begin
            if (timeout_hit) begin
              out_abort <= 1'b1;
              row_q     <= '0;
              col_q     <= '0;
              to_cnt    <= '0;
            end else if (press) begin
              to_cnt <= '0;
              if (state == ST_COL) begin
                col_q <= in_diff_cell_val;
              end else begin
                out_move_cell  <= {row_q, col_q};
                out_move_val   <= code_to_digit(in_diff_cell_val);
                out_move_valid <= 1'b1;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (out_move_valid && in_move_ready) out_move_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_state = state;

endmodule

// File: tb/tb_sudoku_input_decoder.sv
// tb/tb_sudoku_input_decoder.sv - scoreboard bench for sudoku_input_decoder
module tb_sudoku_input_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       enter = 1'b0;
  logic [1:0] code = 2'd0;
  logic       ready = 1'b0;
  logic       solved = 1'b0;
  logic [1:0] diff;
  logic       diff_valid;
  logic       move_valid;
  logic [3:0] move_cell;
  logic [2:0] move_val;
  logic       f_diff, f_row, f_col, f_val;
  logic       abort_p;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;

  logic [1:0] exp_diff_q[$];
  logic [6:0] exp_move_q[$];
  int         exp_abort_q[$];

  sudoku_input_decoder dut (
    .in_clka          (clk),
    .in_restart       (rst),
    .in_new_game      (new_game),
    .in_enter         (enter),
    .in_diff_cell_val (code),
    .in_move_ready    (ready),
    .in_solved        (solved),
    .out_diff         (diff),
    .out_diff_valid   (diff_valid),
    .out_move_valid   (move_valid),
    .out_move_cell    (move_cell),
    .out_move_val     (move_val),
    .out_set_diff_flag(f_diff),
    .out_row_flag     (f_row),
    .out_col_flag     (f_col),
    .out_val_flag     (f_val),
    .out_abort        (abort_p),
    .out_state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [1:0] c);
    @(posedge clk); #2;
    enter = 1'b1; code = c;
    @(posedge clk); #2;
    enter = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  logic       prev_valid = 1'b0;
  logic [3:0] prev_cell = '0;
  logic [2:0] prev_val = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (diff_valid) begin
        if (exp_diff_q.size() == 0) chk("unexpected_diff_pulse", 1, 0);
        else chk("diff_value", int'(diff), int'(exp_diff_q.pop_front()));
      end
      if (abort_p) begin
        if (exp_abort_q.size() == 0) chk("unexpected_abort", 1, 0);
        else chk("abort_pulse", 1, exp_abort_q.pop_front());
      end
      if (move_valid) valid_cycles++;
      if (prev_valid && move_valid)
        chk("move_held_stable", int'({move_cell, move_val}), int'({prev_cell, prev_val}));
      if (move_valid && ready) begin
        if (exp_move_q.size() == 0) chk("unexpected_move", 1, 0);
        else chk("move_cell_val", int'({move_cell, move_val}), int'(exp_move_q.pop_front()));
      end
      prev_valid = move_valid && !ready;
      prev_cell  = move_cell;
      prev_val   = move_val;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    int n;
    // 1: reset, new game, difficulty 2
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'({diff, diff_valid, move_valid, move_cell, move_val,
                               f_diff, f_row, f_col, f_val, abort_p}), 0);
    new_game = 1'b1; tick(1); new_game = 1'b0;
    chk("new_game_state_diff", int'(state), 1);
    chk("set_diff_flag", int'({f_diff, f_row, f_col, f_val}), 4'b1000);
    exp_diff_q.push_back(2'd2);
    press(2'd2);
    chk("after_diff_state_row", int'(state), 2);
    chk("row_flag", int'({f_diff, f_row, f_col, f_val}), 4'b0100);

    // 2: move row1 col2 code3 with ready high -> cell 6, digit 4
    ready = 1'b1;
    valid_cycles = 0;
    exp_move_q.push_back({4'd6, 3'd4});
    press(2'd1);
    chk("col_flag", int'({f_diff, f_row, f_col, f_val}), 4'b0010);
    press(2'd2);
    chk("val_flag", int'({f_diff, f_row, f_col, f_val}), 4'b0001);
    press(2'd3);
    tick(1);
    chk("valid_one_cycle", valid_cycles, 1);
    chk("move2_state_row", int'(state), 2);

    // 3: ready low, move row3 col1 code0 -> cell 13, digit 1; press dropped in WAIT
    ready = 1'b0;
    exp_move_q.push_back({4'd13, 3'd1});
    press(2'd3);
    press(2'd1);
    press(2'd0);
    chk("wait_state", int'(state), 5);
    press(2'd2);
    tick(1);
    chk("wait_after_press", int'(state), 5);
    chk("valid_held", int'(move_valid), 1);
    ready = 1'b1;
    tick(1);
    chk("move3_state_row", int'(state), 2);

    // 4: level held 10 cycles counts once
    @(posedge clk); #2;
    enter = 1'b1; code = 2'd1;
    repeat (10) @(posedge clk);
    #2; enter = 1'b0;
    chk("held_enter_col", int'(state), 3);

    // 5: timeout 64 cycles after the row press
    exp_abort_q.push_back(1);
    tick(50);
    chk("no_early_abort", int'(state), 3);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (state != 3'd2 && n < 20);
    chk("abort_cycle", n, 5);
    exp_move_q.push_back({4'd0, 3'd1});
    press(2'd0);
    press(2'd0);
    press(2'd0);
    tick(1);
    chk("move0_state_row", int'(state), 2);

    // 6: solved, new game with simultaneous press, async reset mid-VAL
    solved = 1'b1;
    tick(1);
    chk("solved_done", int'(state), 6);
    press(2'd1);
    chk("done_ignores_press", int'(state), 6);
    solved = 1'b0;
    @(posedge clk); #2;
    new_game = 1'b1; enter = 1'b1; code = 2'd3;
    tick(1);
    new_game = 1'b0; enter = 1'b0;
    tick(1);
    chk("ng_press_state_diff", int'(state), 1);
    chk("ng_clears_diff", int'(diff), 0);
    exp_diff_q.push_back(2'd1);
    press(2'd1);
    press(2'd2);
    press(2'd3);
    chk("mid_val_state", int'(state), 4);
    chk("diff_latched", int'(diff), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({state, diff, diff_valid, move_valid, move_cell, move_val,
                                     f_diff, f_row, f_col, f_val, abort_p}), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("scoreboard_drained", exp_diff_q.size() + exp_move_q.size() + exp_abort_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
